// File: rtl/cache_controller_if.sv
// Signal bundle between the cache controller and its CPU, tag RAM and main memory.
// The master modport is the controller's view; slave is the surrounding system.
interface cache_controller_if #(
  parameter int INDEX      = 3,
  parameter int MEMORYBITS = 5,
  parameter int DATAWIDTH  = 8
);
  logic                        cpu_req;
  logic                        cpu_we;
  logic [MEMORYBITS-1:0]       cpu_addr;
  logic [DATAWIDTH-1:0]        cpu_wdata;
  logic [DATAWIDTH-1:0]        cpu_rdata;
  logic                        cpu_ready;
  logic                        busy;
  logic [INDEX-1:0]            tag_index;
  logic                        tag_read;
  logic                        tag_write;
  logic [MEMORYBITS-INDEX-1:0] tag_wdata;
  logic [MEMORYBITS-INDEX-1:0] tag_rdata;
  logic [MEMORYBITS-1:0]       mem_addr;
  logic                        mem_rd;
  logic                        mem_wr;
  logic [DATAWIDTH-1:0]        mem_wdata;
  logic [DATAWIDTH-1:0]        mem_rdata;
  logic                        mem_ack;
  logic [7:0]                  hit_count;
  logic [7:0]                  miss_count;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, tag_rdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, busy, tag_index, tag_read, tag_write, tag_wdata,
           mem_addr, mem_rd, mem_wr, mem_wdata, hit_count, miss_count
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, tag_rdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, busy, tag_index, tag_read, tag_write, tag_wdata,
           mem_addr, mem_rd, mem_wr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped write-through cache controller: owns valid bits and data array,
// drives an external registered tag RAM and sequences refills/write-throughs.
module cache_controller #(
  parameter int INDEX      = 3,
  parameter int CACHESIZE  = 8,
  parameter int MEMORYBITS = 5,
  parameter int DATAWIDTH  = 8
) (
  input logic                clk,
  input logic                reset,
  cache_controller_if.master cif
);
  localparam int TAGBITS = MEMORYBITS - INDEX;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    FILL   = 3'd3,
    MEM_WR = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic [MEMORYBITS-1:0] addr_r;
  logic                  we_r;
  logic [DATAWIDTH-1:0]  wdata_r;
  logic [DATAWIDTH-1:0]  fill_r;
  logic [DATAWIDTH-1:0]  cpu_rdata_r;
  logic [CACHESIZE-1:0]  valid_r;
  logic [DATAWIDTH-1:0]  data_r [CACHESIZE];
  logic [7:0]            hit_count_r;
  logic [7:0]            miss_count_r;
  logic                  cpu_ready_r;
  logic                  busy_r;
  logic                  tag_write_r;
  logic                  mem_rd_r;
  logic                  mem_wr_r;
  logic [INDEX-1:0]      idx_s;
  logic [TAGBITS-1:0]    tag_s;
  logic                  hit_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign idx_s = addr_r[INDEX-1:0];
  assign tag_s = addr_r[MEMORYBITS-1:INDEX];
  // tag_rdata is only meaningful in LOOKUP, one clock after the IDLE tag_read
  assign hit_s = valid_r[idx_s] & (cif.tag_rdata == tag_s);

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = cif.cpu_req ? LOOKUP : IDLE;
      LOOKUP: begin
        if (we_r) begin
          next_state_s = MEM_WR;
        end else if (hit_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = MEM_RD;
        end
      end
      MEM_RD:  next_state_s = cif.mem_ack ? FILL : MEM_RD;
      FILL:    next_state_s = DONE;
      MEM_WR:  next_state_s = cif.mem_ack ? DONE : MEM_WR;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register and state-decoded control outputs, registered from next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cpu_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      tag_write_r <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      cpu_ready_r <= (next_state_s == DONE);
      busy_r      <= (next_state_s != IDLE);
      tag_write_r <= (next_state_s == FILL);
      mem_rd_r    <= (next_state_s == MEM_RD);
      mem_wr_r    <= (next_state_s == MEM_WR);
    end
  end

  // Request latch, valid bits, refill capture, read data and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r       <= '0;
      we_r         <= 1'b0;
      wdata_r      <= '0;
      fill_r       <= '0;
      cpu_rdata_r  <= '0;
      valid_r      <= '0;
      hit_count_r  <= 8'd0;
      miss_count_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cif.cpu_req) begin
            addr_r  <= cif.cpu_addr;
            we_r    <= cif.cpu_we;
            wdata_r <= cif.cpu_wdata;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            hit_count_r <= sat_inc(hit_count_r);
          end else begin
            miss_count_r <= sat_inc(miss_count_r);
          end
          if (!we_r && hit_s) begin
            cpu_rdata_r <= data_r[idx_s];
          end
        end
        MEM_RD: begin
          if (cif.mem_ack) begin
            fill_r <= cif.mem_rdata;
          end
        end
        FILL: begin
          valid_r[idx_s] <= 1'b1;
          cpu_rdata_r    <= fill_r;
        end
        default: begin
        end
      endcase
    end
  end

  // Data array: updated on write hit and on refill; contents survive reset
  always_ff @(posedge clk) begin
    if ((state_r == LOOKUP) && we_r && hit_s) begin
      data_r[idx_s] <= wdata_r;
    end else if (state_r == FILL) begin
      data_r[idx_s] <= fill_r;
    end
  end

  // The tag lookup must be launched combinationally so tag_rdata is ready in LOOKUP
  assign cif.tag_read   = (state_r == IDLE) & cif.cpu_req & ~reset;
  assign cif.tag_index  = (state_r == IDLE) ? cif.cpu_addr[INDEX-1:0] : idx_s;
  assign cif.tag_write  = tag_write_r;
  assign cif.tag_wdata  = tag_s;
  assign cif.cpu_rdata  = cpu_rdata_r;
  assign cif.cpu_ready  = cpu_ready_r;
  assign cif.busy       = busy_r;
  assign cif.mem_addr   = addr_r;
  assign cif.mem_rd     = mem_rd_r;
  assign cif.mem_wr     = mem_wr_r;
  assign cif.mem_wdata  = wdata_r;
  assign cif.hit_count  = hit_count_r;
  assign cif.miss_count = miss_count_r;
endmodule

// File: tb/tb_cache_controller.sv
// Directed scoreboard bench for cache_controller with a behavioural registered
// tag RAM and a main-memory responder whose ack delay is set per transaction.
module tb_cache_controller;
  localparam int INDEX      = 3;
  localparam int CACHESIZE  = 8;
  localparam int MEMORYBITS = 5;
  localparam int DATAWIDTH  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  cache_controller_if #(.INDEX(INDEX), .MEMORYBITS(MEMORYBITS), .DATAWIDTH(DATAWIDTH)) bus ();

  cache_controller #(
    .INDEX(INDEX), .CACHESIZE(CACHESIZE), .MEMORYBITS(MEMORYBITS), .DATAWIDTH(DATAWIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .cif  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard queues
  logic [7:0]  sb_rdata[$];
  int          sb_cyc[$];
  logic [13:0] sb_mem[$];   // {is_write, addr, wdata}
  logic [4:0]  sb_tag[$];   // {index, tag}

  int         exp_hit  = 0;
  int         exp_miss = 0;
  logic [7:0] last_rd  = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // registered tag RAM
  logic       tag_clr = 1'b1;
  logic [1:0] tag_mem [8];
  always @(posedge clk) begin
    if (tag_clr) begin
      for (int i = 0; i < 8; i++) tag_mem[i] <= 2'b00;
      bus.tag_rdata <= 2'b00;
    end else begin
      if (bus.tag_read) bus.tag_rdata <= tag_mem[bus.tag_index];
      if (bus.tag_write) tag_mem[bus.tag_index] <= bus.tag_wdata;
    end
  end

  // main-memory responder: ack after mem_n cycles of mem_rd/mem_wr
  int         mem_n     = 1;
  logic [7:0] mem_data  = 8'h00;
  bit         force_ack = 1'b0;
  initial begin
    int mem_cnt;
    mem_cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        mem_cnt = 0;
      end else if (force_ack) begin
        bus.mem_ack = 1'b1;
      end else if (bus.mem_rd || bus.mem_wr) begin
        mem_cnt++;
        if (mem_cnt == mem_n) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_data;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents an event
  initial begin
    bit          prev_rd;
    bit          prev_wr;
    logic [13:0] me;
    logic [4:0]  te;
    logic [7:0]  er;
    int          ec;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.cpu_ready) begin
        if (sb_rdata.size() == 0) begin
          unexpected("cpu_ready");
        end else begin
          er = sb_rdata.pop_front();
          ec = sb_cyc.pop_front();
          check("cpu_rdata", int'(bus.cpu_rdata), int'(er));
          check("ready_latency", cyc, ec);
        end
        done_cnt++;
      end
      if (bus.mem_rd && !prev_rd) begin
        if (sb_mem.size() == 0) begin
          unexpected("mem_rd");
        end else begin
          me = sb_mem.pop_front();
          check("mem_rd_kind", 0, int'(me[13]));
          check("mem_rd_addr", int'(bus.mem_addr), int'(me[12:8]));
        end
      end
      if (bus.mem_wr && !prev_wr) begin
        if (sb_mem.size() == 0) begin
          unexpected("mem_wr");
        end else begin
          me = sb_mem.pop_front();
          check("mem_wr_kind", 1, int'(me[13]));
          check("mem_wr_addr", int'(bus.mem_addr), int'(me[12:8]));
          check("mem_wdata", int'(bus.mem_wdata), int'(me[7:0]));
        end
      end
      if (bus.tag_write) begin
        if (sb_tag.size() == 0) begin
          unexpected("tag_write");
        end else begin
          te = sb_tag.pop_front();
          check("tag_index", int'(bus.tag_index), int'(te[4:2]));
          check("tag_wdata", int'(bus.tag_wdata), int'(te[1:0]));
          check("tag_rd_wr_excl", int'(bus.tag_read), 0);
        end
      end
      prev_rd = bus.mem_rd;
      prev_wr = bus.mem_wr;
    end
  end

  // one CPU transaction; data is write data, or the expected read data (also the refill word)
  task automatic cpu_op(input bit we, input bit hit, input logic [4:0] addr,
                        input logic [7:0] data, input int n, input bit poke);
    int   start;
    int   k;
    int   lat;
    logic [4:0] a;
    @(negedge clk);
    mem_n    = n;
    mem_data = data;
    lat = we ? n + 2 : (hit ? 2 : n + 3);
    if (we) begin
      sb_rdata.push_back(last_rd);
      sb_mem.push_back({1'b1, addr, data});
    end else begin
      sb_rdata.push_back(data);
      last_rd = data;
      if (!hit) begin
        sb_mem.push_back({1'b0, addr, 8'h00});
        sb_tag.push_back({addr[2:0], addr[4:3]});
      end
    end
    sb_cyc.push_back(cyc + lat);
    if (hit) exp_hit = (exp_hit == 255) ? 255 : exp_hit + 1;
    else     exp_miss = (exp_miss == 255) ? 255 : exp_miss + 1;
    start = done_cnt;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = data;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    if (poke) begin
      // a request while busy must be dropped
      @(negedge clk);
      a = ~addr;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = a;
      @(posedge clk);
      #1;
      bus.cpu_req = 1'b0;
    end
    k = 0;
    while (done_cnt == start && k < 64) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (done_cnt == start) begin
      checks++;
      failures++;
      $display("FAIL op_timeout actual=no_ready required=ready addr=%0h", addr);
    end
    check("hit_count", int'(bus.hit_count), exp_hit);
    check("miss_count", int'(bus.miss_count), exp_miss);
  endtask

  initial begin
    int k;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 5'd0;
    bus.cpu_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ready", int'(bus.cpu_ready), 0);
    check("rst_hits", int'(bus.hit_count), 0);
    check("rst_misses", int'(bus.miss_count), 0);
    check("rst_rdata", int'(bus.cpu_rdata), 0);
    check("rst_mem_rd", int'(bus.mem_rd), 0);
    check("rst_tag_write", int'(bus.tag_write), 0);
    @(negedge clk);
    reset   = 1'b0;
    tag_clr = 1'b0;

    cpu_op(1'b0, 1'b0, 5'b10011, 8'hA5, 2, 1'b0);   // cold read miss
    @(posedge clk); #1 force_ack = 1'b1;            // stray ack while idle
    @(posedge clk); #1 force_ack = 1'b0;
    cpu_op(1'b0, 1'b1, 5'b10011, 8'hA5, 1, 1'b0);   // read hit
    cpu_op(1'b1, 1'b1, 5'b10011, 8'h3C, 1, 1'b0);   // write hit, write-through
    cpu_op(1'b0, 1'b1, 5'b10011, 8'h3C, 1, 1'b0);   // read back written word
    cpu_op(1'b0, 1'b0, 5'b01011, 8'h5A, 3, 1'b1);   // conflict miss, busy req ignored
    cpu_op(1'b0, 1'b0, 5'b10011, 8'h3C, 1, 1'b0);   // evicted line misses again
    cpu_op(1'b1, 1'b0, 5'b00111, 8'h77, 2, 1'b0);   // write miss, no allocate
    cpu_op(1'b0, 1'b0, 5'b00111, 8'h77, 1, 1'b0);   // still a miss afterwards

    // reset in the middle of a refill
    @(negedge clk);
    mem_n = 1000;
    sb_mem.push_back({1'b0, 5'b11011, 8'h00});
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 5'b11011;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    k = 0;
    while (!bus.mem_rd && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("abort_reached_mem_rd", int'(bus.mem_rd), 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_mem_rd", int'(bus.mem_rd), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_misses", int'(bus.miss_count), 0);
    check("abort_rdata", int'(bus.cpu_rdata), 0);
    exp_hit  = 0;
    exp_miss = 0;
    last_rd  = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1 force_ack = 1'b1;
    @(posedge clk); #1 force_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stray_ack_busy", int'(bus.busy), 0);
    check("stray_ack_mem_rd", int'(bus.mem_rd), 0);
    cpu_op(1'b0, 1'b0, 5'b10011, 8'h3C, 1, 1'b0);   // valid bits were cleared

    // hit counter saturation
    for (int i = 0; i < 258; i++) cpu_op(1'b0, 1'b1, 5'b10011, 8'h3C, 1, 1'b0);
    check("hit_saturated", int'(bus.hit_count), 255);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb_rdata.size() + sb_mem.size() + sb_tag.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule
